// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback bus of the register file: two read ports with busy status,
// one writeback port and one issue port.
interface regfile_scoreboard_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 5
);
  logic [ADDR_W-1:0] read_register_1;
  logic [ADDR_W-1:0] read_register_2;
  logic [DATA_W-1:0] read_data_1;
  logic [DATA_W-1:0] read_data_2;
  logic              busy_1;
  logic              busy_2;
  logic              reg_write;
  logic [ADDR_W-1:0] write_register;
  logic [DATA_W-1:0] write_data;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_register;

  // Core side: drives indices, writeback and issue; consumes read data.
  modport master (
    output read_register_1, read_register_2,
    input  read_data_1, read_data_2, busy_1, busy_2,
    output reg_write, write_register, write_data,
    output issue_valid, issue_register
  );

  // Register file side.
  modport slave (
    input  read_register_1, read_register_2,
    output read_data_1, read_data_2, busy_1, busy_2,
    input  reg_write, write_register, write_data,
    input  issue_valid, issue_register
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Parametrised 2R/1W register file with a per-register busy scoreboard.
// Optional macro REGFILE_BYPASS_EN enables same-cycle write-through forwarding.
module regfile_scoreboard #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_scoreboard_if.slave  bus
);
  localparam int unsigned ADDR_W  = $clog2(NUM_REGS);
  localparam logic        ZERO_EN = (ZERO_REG != 0);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;
  logic                wr_en;

  assign wr_en = bus.reg_write && !(ZERO_EN && bus.write_register == '0);

  // Register storage; index 0 is never written when hardwired to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[bus.write_register] <= bus.write_data;
    end
  end

  // Scoreboard next state: clear on writeback, then set on issue (younger producer wins).
  always_comb begin
    busy_nxt = busy;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (bus.reg_write && bus.write_register == ADDR_W'(i)) busy_nxt[i] = 1'b0;
      if (bus.issue_valid && bus.issue_register == ADDR_W'(i)) busy_nxt[i] = 1'b1;
    end
    if (ZERO_EN) busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  // Read port 1.
  always_comb begin
    bus.read_data_1 = regs[bus.read_register_1];
    bus.busy_1      = busy[bus.read_register_1];
`ifdef REGFILE_BYPASS_EN
    if (rst_n && bus.reg_write && bus.write_register == bus.read_register_1) begin
      bus.read_data_1 = bus.write_data;
      bus.busy_1      = bus.issue_valid && bus.issue_register == bus.read_register_1;
    end
`endif
    if (ZERO_EN && bus.read_register_1 == '0) begin
      bus.read_data_1 = '0;
      bus.busy_1      = 1'b0;
    end
  end

  // Read port 2.
  always_comb begin
    bus.read_data_2 = regs[bus.read_register_2];
    bus.busy_2      = busy[bus.read_register_2];
`ifdef REGFILE_BYPASS_EN
    if (rst_n && bus.reg_write && bus.write_register == bus.read_register_2) begin
      bus.read_data_2 = bus.write_data;
      bus.busy_2      = bus.issue_valid && bus.issue_register == bus.read_register_2;
    end
`endif
    if (ZERO_EN && bus.read_register_2 == '0) begin
      bus.read_data_2 = '0;
      bus.busy_2      = 1'b0;
    end
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard (ZERO_REG=1, 32x64).
module tb_regfile_scoreboard;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  regfile_scoreboard_if #(.DATA_W(64), .ADDR_W(5)) bus ();

  regfile_scoreboard #(.DATA_W(64), .NUM_REGS(32), .ZERO_REG(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.read_register_1 = 5'd5;
    bus.read_register_2 = 5'd5;
    bus.reg_write       = 1'b1;
    bus.write_register  = 5'd5;
    bus.write_data      = 64'hFF;
    bus.issue_valid     = 1'b1;
    bus.issue_register  = 5'd5;

    // Reset holds everything at zero despite writes and issues.
    #1;
    chk("rst_data_t0", bus.read_data_1, 64'h0);
    chk("rst_busy_t0", 64'(bus.busy_1), 64'h0);
    tick();
    chk("rst_data_t1", bus.read_data_1, 64'h0);
    chk("rst_busy_t1", 64'(bus.busy_1), 64'h0);
    tick();
    chk("rst_data_t2", bus.read_data_2, 64'h0);
    chk("rst_busy_t2", 64'(bus.busy_2), 64'h0);

    // Release reset and write r5.
    rst_n           = 1'b1;
    bus.issue_valid = 1'b0;
    tick();
    bus.reg_write = 1'b0;
    #1;
    chk("post_rst_r5", bus.read_data_1, 64'hFF);
    chk("post_rst_r5_busy", 64'(bus.busy_1), 64'h0);

    // Dual read.
    bus.reg_write = 1'b1; bus.write_register = 5'd3; bus.write_data = 64'hDEAD_BEEF;
    tick();
    bus.write_register = 5'd4; bus.write_data = 64'h1234;
    tick();
    bus.reg_write = 1'b0;
    bus.read_register_1 = 5'd3; bus.read_register_2 = 5'd4;
    #1;
    chk("dual_rd1_r3", bus.read_data_1, 64'hDEAD_BEEF);
    chk("dual_rd2_r4", bus.read_data_2, 64'h1234);
    bus.read_register_2 = 5'd3;
    #1;
    chk("same_rd1_r3", bus.read_data_1, 64'hDEAD_BEEF);
    chk("same_rd2_r3", bus.read_data_2, 64'hDEAD_BEEF);

    // Zero register: writes and issues dropped, never forwarded.
    tick();
    bus.read_register_1 = 5'd0;
    bus.reg_write = 1'b1; bus.write_register = 5'd0; bus.write_data = 64'hAAAA;
    bus.issue_valid = 1'b1; bus.issue_register = 5'd0;
    #1;
    chk("zero_same_cycle", bus.read_data_1, 64'h0);
    chk("zero_same_busy", 64'(bus.busy_1), 64'h0);
    tick();
    bus.reg_write = 1'b0; bus.issue_valid = 1'b0;
    #1;
    chk("zero_data_c1", bus.read_data_1, 64'h0);
    chk("zero_busy_c1", 64'(bus.busy_1), 64'h0);
    tick();
    chk("zero_data_c2", bus.read_data_1, 64'h0);

    // Scoreboard set, clear, and set-wins.
    bus.read_register_1 = 5'd7; bus.read_register_2 = 5'd8;
    bus.issue_valid = 1'b1; bus.issue_register = 5'd7;
    #1;
    chk("sb_busy_before", 64'(bus.busy_1), 64'h0);
    tick();
    bus.issue_valid = 1'b0;
    #1;
    chk("sb_busy_set", 64'(bus.busy_1), 64'h1);
    chk("sb_neighbor_idle", 64'(bus.busy_2), 64'h0);
    bus.reg_write = 1'b1; bus.write_register = 5'd7; bus.write_data = 64'h77;
    tick();
    bus.reg_write = 1'b0;
    #1;
    chk("sb_busy_clear", 64'(bus.busy_1), 64'h0);
    chk("sb_wb_data", bus.read_data_1, 64'h77);
    bus.issue_valid = 1'b1; bus.issue_register = 5'd7;
    bus.reg_write = 1'b1; bus.write_register = 5'd7; bus.write_data = 64'h7777;
    tick();
    bus.issue_valid = 1'b0; bus.reg_write = 1'b0;
    #1;
    chk("sb_set_wins", 64'(bus.busy_1), 64'h1);
    chk("sb_set_wins_data", bus.read_data_1, 64'h7777);

    // Same-cycle write visibility on data and busy.
    bus.read_register_2 = 5'd9;
    bus.reg_write = 1'b1; bus.write_register = 5'd9; bus.write_data = 64'h99;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_same_cycle", bus.read_data_2, 64'h99);
`else
    chk("byp_same_cycle", bus.read_data_2, 64'h0);
`endif
    tick();
    bus.reg_write = 1'b0;
    #1;
    chk("byp_next_cycle", bus.read_data_2, 64'h99);
    bus.read_register_1 = 5'd10;
    bus.issue_valid = 1'b1; bus.issue_register = 5'd10;
    tick();
    bus.issue_valid = 1'b0;
    bus.reg_write = 1'b1; bus.write_register = 5'd10; bus.write_data = 64'hA0;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_busy_same", 64'(bus.busy_1), 64'h0);
    chk("byp_data_same", bus.read_data_1, 64'hA0);
`else
    chk("byp_busy_same", 64'(bus.busy_1), 64'h1);
    chk("byp_data_same", bus.read_data_1, 64'h0);
`endif
    tick();
    bus.reg_write = 1'b0;
    #1;
    chk("byp_busy_after", 64'(bus.busy_1), 64'h0);

    // Reset mid-operation clears immediately.
    bus.reg_write = 1'b1; bus.write_register = 5'd2; bus.write_data = 64'h5;
    bus.issue_valid = 1'b1; bus.issue_register = 5'd2;
    tick();
    bus.reg_write = 1'b0; bus.issue_valid = 1'b0;
    bus.read_register_1 = 5'd2; bus.read_register_2 = 5'd3;
    #1;
    chk("mid_pre_data", bus.read_data_1, 64'h5);
    chk("mid_pre_busy", 64'(bus.busy_1), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_data", bus.read_data_1, 64'h0);
    chk("mid_rst_busy", 64'(bus.busy_1), 64'h0);
    chk("mid_rst_r3", bus.read_data_2, 64'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid_after_r2", bus.read_data_1, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the 32x64 two-read/one-write register file.
- Generalised in data width and register count; optional hardwired-zero register.
- Adds an asynchronous active-low reset that clears all state.
- Adds a per-register busy scoreboard for the pipelined core: set on instruction issue, cleared on writeback. Sits between decode (reads, busy check) and writeback (write port).

Parameters:
- DATA_W, 64, width of each register and of the data ports.
- NUM_REGS, 32, number of architectural registers; must be a power of two and at least 2.
- ADDR_W, $clog2(NUM_REGS), register index width; derived from NUM_REGS, never overridden.
- ZERO_REG, 1, when 1, register 0 reads as zero, ignores writes and is never busy.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset; assertion takes effect immediately, release is synchronous to clk.
- read_register_1  in  ADDR_W  read port 1 index.
- read_register_2  in  ADDR_W  read port 2 index.
- read_data_1  out  DATA_W  contents of read_register_1.
- read_data_2  out  DATA_W  contents of read_register_2.
- busy_1  out  1  scoreboard bit of read_register_1.
- busy_2  out  1  scoreboard bit of read_register_2.
- reg_write  in  1  writeback enable.
- write_register  in  ADDR_W  writeback index.
- write_data  in  DATA_W  writeback data.
- issue_valid  in  1  marks issue_register as pending (busy).
- issue_register  in  ADDR_W  destination index of the issued instruction.

Behaviour:
- Storage: NUM_REGS x DATA_W flops plus NUM_REGS busy flops.
- Reset:
  - While rst_n=0, every register is 0 and every busy bit is 0.
  - Consequently read_data_1/2=0 and busy_1/2=0 during reset, independent of clk.
  - Reset asserted mid-operation discards pending writes and issues in that cycle.
- Reads:
  - Combinational (zero-cycle latency) from the current register contents.
  - The two ports are independent; both may address the same register.
- Writes:
  - When reg_write=1 at a rising edge, reg[write_register] <= write_data.
  - The new value is visible on the read ports from the following cycle.
- Scoreboard, per index i, at each rising edge:
  - Set when issue_valid=1 and issue_register=i.
  - Cleared when reg_write=1 and write_register=i.
  - Both events on the same i in one cycle: set wins, busy stays or becomes 1, because the new producer is younger.
  - Neither event: hold.
  - Clearing a register that is not busy is legal; the write still occurs.
- busy_1/busy_2: combinational read of the scoreboard at read_register_1/2.
- ZERO_REG=1:
  - Index 0 always reads 0 and busy=0.
  - Writes to index 0 are dropped; issues to index 0 are dropped.
- ZERO_REG=0: register 0 behaves like any other register.
- No X propagation: every index is in range because NUM_REGS is a power of two.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined: write-through forwarding.
  - If reg_write=1 and write_register equals read_register_N in the same cycle, read_data_N=write_data and busy_N=0 combinationally.
  - Exception: if issue_valid=1 targets the same index in that cycle, busy_N=1.
  - Forwarding never applies to index 0 when ZERO_REG=1.
- Undefined: reads in the writing cycle return the old register value and the old busy bit; the update appears the next cycle.

Test Plan:
- Reset: hold rst_n=0, drive reg_write=1, write_register=5, write_data=64'hFF, toggle clk -> read_data_1=0 and busy_1=0 for read_register_1=5 throughout; release rst_n, write again -> reg5=64'hFF the next cycle.
- Dual read: write r3=64'hDEAD_BEEF and r4=64'h1234 on consecutive edges; read_register_1=3, read_register_2=4 -> read_data_1=64'hDEAD_BEEF, read_data_2=64'h1234; both ports on index 3 -> both 64'hDEAD_BEEF.
- Zero register (ZERO_REG=1): write r0=64'hAAAA and issue r0 -> read_data_1=0 and busy_1=0 on every subsequent cycle.
- Scoreboard: issue r7 -> busy_1=1 next cycle for read_register_1=7; writeback r7=64'h77 -> busy_1=0 and read_data_1=64'h77 next cycle; same-cycle issue r7 plus writeback r7 -> busy_1 remains 1 and data=new value.
- Bypass:
  - With REGFILE_BYPASS_EN: write r9=64'h99 while read_register_2=9 -> read_data_2=64'h99 in the same cycle.
  - Without REGFILE_BYPASS_EN: the old value in that cycle, 64'h99 the next cycle.
- Reset mid-operation: with r2=64'h5 and r2 busy, assert rst_n=0 between clock edges -> read_data and busy drop to 0 immediately, before the next edge.
